// File: rtl/uart_cal_pkg.sv
// -----------------------------------------------------------------------------
// uart_cal_pkg
// Shared definitions for the UART calculator return path: the ASCII byte
// constants that make up a printed result, the result_decoder state encoding,
// and a helper that turns one packed BCD digit into its ASCII character.
// No ports; imported by result_decoder.
// -----------------------------------------------------------------------------
package uart_cal_pkg;

    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_E     = 8'h45;
    localparam logic [7:0] CHAR_R     = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_LOAD,
        S_SIGN,
        S_DIGIT,
        S_ERR,
        S_CR,
        S_LF
    } dec_state_t;

    // ASCII character for digit idx (0 = units) of a 10-digit packed BCD word.
    function automatic logic [7:0] digit_char(input logic [39:0] bcd, input logic [3:0] idx);
        return CHAR_0 + {4'h0, bcd[{idx, 2'b00} +: 4]};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: 32-bit unsigned binary to 10 packed BCD
// digits, one input bit per cycle, always 32 shift cycles after a load.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   load      capture bin and clear the BCD accumulator
//   bin       binary value to convert
//   bcd       10 BCD digits, digit 0 (units) in bits [3:0]; held after done
//   bcd_done  one-cycle pulse once the 32nd shift has completed
// -----------------------------------------------------------------------------
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] bin,
    output logic [39:0] bcd,
    output logic        bcd_done
);

    logic [31:0] shreg;
    logic [5:0]  cnt;
    logic [39:0] bcd_adj;

    // Add-3 correction on every digit that would overflow past 9 when doubled.
    always_comb begin
        // NOTE: assign a default before any conditional update so the
        // combinational block can never infer a latch.
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            bcd_done <= 1'b0;
        end else begin
            bcd_done <= 1'b0;
            if (load) begin
                shreg <= bin;
                bcd   <= '0;
                cnt   <= 6'd32;
            end else if (cnt != 6'd0) begin
                {bcd, shreg} <= {bcd_adj[38:0], shreg, 1'b0};
                cnt          <= cnt - 6'd1;
                if (cnt == 6'd1) begin
                    bcd_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/result_decoder.sv
// -----------------------------------------------------------------------------
// result_decoder
// Turns a 32-bit ALU result into an ASCII decimal line for the UART
// transmitter: optional '-', digits without leading zeros, then CR LF (or LF
// only), or "ERR" plus end-of-line when the core flags an error.
// Parameters:
//   EOL_CRLF  1: end lines with 0x0D 0x0A; 0: end lines with 0x0A only
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   start                request, accepted only while busy=0
//   result, is_signed    value and its signedness, sampled on accepted start
//   err                  print "ERR" instead of the value
//   busy                 high from the cycle after acceptance until done
//   tx_data, tx_valid    registered byte stream to the transmitter
//   tx_ready             transmitter accepts when tx_valid & tx_ready
//   done                 one-cycle pulse after the final LF is accepted
// -----------------------------------------------------------------------------
module result_decoder
    import uart_cal_pkg::*;
#(
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] result,
    input  logic        is_signed,
    input  logic        err,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    localparam dec_state_t EOL_STATE = EOL_CRLF ? S_CR : S_LF;
    localparam logic [7:0] EOL_FIRST = EOL_CRLF ? CHAR_CR : CHAR_LF;

    dec_state_t  state;
    logic        neg_q;
    logic [3:0]  digit_idx;
    logic [1:0]  err_cnt;

    logic        neg_in;
    logic [31:0] mag;
    logic        conv_load;
    logic        handshake;
    logic [39:0] bcd;
    logic        bcd_done;
    logic [3:0]  first_idx;

    // Two's-complement negate as unsigned: 0x80000000 maps to 2147483648.
    assign neg_in    = is_signed & result[31];
    assign mag       = neg_in ? (~result + 32'd1) : result;
    assign conv_load = (state == S_IDLE) && start && !err;
    assign handshake = tx_valid && tx_ready;

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .load     (conv_load),
        .bin      (mag),
        .bcd      (bcd),
        .bcd_done (bcd_done)
    );

    // Most significant non-zero digit; stays 0 for a zero value so "0" prints.
    always_comb begin
        first_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) begin
                first_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            done      <= 1'b0;
            neg_q     <= 1'b0;
            digit_idx <= 4'd0;
            err_cnt   <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        neg_q   <= neg_in;
                        err_cnt <= 2'd0;
                        state   <= err ? S_ERR : S_CONV;
                    end
                end
                S_CONV: begin
                    if (bcd_done) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    digit_idx <= first_idx;
                    tx_valid  <= 1'b1;
                    if (neg_q) begin
                        state   <= S_SIGN;
                        tx_data <= CHAR_MINUS;
                    end else begin
                        state   <= S_DIGIT;
                        tx_data <= digit_char(bcd, first_idx);
                    end
                end
                S_SIGN: begin
                    if (handshake) begin
                        state   <= S_DIGIT;
                        tx_data <= digit_char(bcd, digit_idx);
                    end
                end
                S_DIGIT: begin
                    if (handshake) begin
                        if (digit_idx == 4'd0) begin
                            state   <= EOL_STATE;
                            tx_data <= EOL_FIRST;
                        end else begin
                            digit_idx <= digit_idx - 4'd1;
                            tx_data   <= digit_char(bcd, digit_idx - 4'd1);
                        end
                    end
                end
                S_ERR: begin
                    // First cycle in this state only raises 'E'; err_cnt then
                    // counts accepted bytes of "ERR".
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= CHAR_E;
                    end else if (handshake) begin
                        if (err_cnt == 2'd2) begin
                            state   <= EOL_STATE;
                            tx_data <= EOL_FIRST;
                        end else begin
                            err_cnt <= err_cnt + 2'd1;
                            tx_data <= CHAR_R;
                        end
                    end
                end
                S_CR: begin
                    if (handshake) begin
                        state   <= S_LF;
                        tx_data <= CHAR_LF;
                    end
                end
                S_LF: begin
                    if (handshake) begin
                        state    <= S_IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_decoder.sv
// -----------------------------------------------------------------------------
// tb_result_decoder
// Directed bench for result_decoder. A CRLF build (dut) and an LF-only build
// (dut_lf) share the same stimulus; each scenario collects the bytes of one
// build and compares them with hand-written expected strings and cycle counts.
// -----------------------------------------------------------------------------
module tb_result_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] result = '0;
    logic        is_signed = 1'b0;
    logic        err = 1'b0;
    logic        tx_ready = 1'b1;

    logic        busy, tx_valid, done;
    logic [7:0]  tx_data;
    logic        lf_busy, lf_valid, lf_done;
    logic [7:0]  lf_data;

    always #5 clk = ~clk;

    result_decoder #(.EOL_CRLF(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .result(result),
        .is_signed(is_signed), .err(err), .busy(busy), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .done(done)
    );

    result_decoder #(.EOL_CRLF(1'b0)) dut_lf (
        .clk(clk), .rst(rst), .start(start), .result(result),
        .is_signed(is_signed), .err(err), .busy(lf_busy), .tx_data(lf_data),
        .tx_valid(lf_valid), .tx_ready(tx_ready), .done(lf_done)
    );

    int checks = 0;
    int errors = 0;

    // Results of the most recent collect() call.
    logic [7:0]  got [16];
    int          got_n, got_first, done_cycle, done_cnt, hold_viol, stall_seen;
    bit          timed_out;
    int          inj_cycle = -1;
    logic [31:0] inj_result = '0;

    // Pulse start for one cycle; returns #1 after the accepting edge (edge 0).
    task automatic do_start(input logic [31:0] r, input logic s, input logic e);
        @(posedge clk);
        #1;
        start = 1'b1; result = r; is_signed = s; err = e;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Sample one build at each falling edge (cycle 0 follows edge 0) and
    // record handshaken bytes; optionally stall byte stall_at for stall_len
    // cycles and inject a start pulse at inj_cycle.
    task automatic collect(input bit sel_lf, input int stall_at, input int stall_len,
                           input int budget);
        logic       v, dn;
        logic [7:0] d, held;
        bit         holding;
        int         stall_left;
        holding = 1'b0; held = 8'h00; stall_left = stall_len;
        got_n = 0; got_first = -1; done_cycle = -1; done_cnt = 0;
        hold_viol = 0; stall_seen = 0; timed_out = 1'b0;
        for (int i = 0; i < 16; i++) got[i] = 8'hxx;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            v  = sel_lf ? lf_valid : tx_valid;
            d  = sel_lf ? lf_data  : tx_data;
            dn = sel_lf ? lf_done  : done;
            start = (cyc == inj_cycle);
            if (cyc == inj_cycle) begin
                result = inj_result; is_signed = 1'b0; err = 1'b0;
            end
            if (v && got_first < 0) got_first = cyc;
            if (dn) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (holding && (!v || d !== held)) hold_viol++;
            if (v && got_n == stall_at && stall_left > 0) begin
                tx_ready = 1'b0;
                if (!holding) held = d;
                holding = 1'b1;
                stall_left--;
                stall_seen++;
            end else begin
                tx_ready = 1'b1;
                holding = 1'b0;
                if (v && got_n < 16) begin
                    got[got_n] = d;
                    got_n++;
                end
            end
            if (done_cycle >= 0 && cyc >= done_cycle + 3) break;
        end
        if (done_cycle < 0) timed_out = 1'b1;
        tx_ready = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", tx_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
    endtask

    // One full conversion with tx_ready held high; exp_first is the cycle
    // where tx_valid first appears, and done follows the last byte.
    task automatic test_value(input string name, input bit sel_lf, input logic [31:0] r,
                              input logic s, input logic e, input string exp, input int exp_first);
        do_start(r, s, e);
        collect(sel_lf, -1, 0, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL %s timeout: got no done expected done", name); end
        checks++; if (got_n !== exp.len()) begin errors++; $display("FAIL %s len: got %0d expected %0d", name, got_n, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++; $display("FAIL %s byte%0d: got %h expected %h", name, i, got[i], exp[i]);
            end
        end
        checks++; if (got_first !== exp_first) begin errors++; $display("FAIL %s first_valid: got %0d expected %0d", name, got_first, exp_first); end
        checks++; if (done_cycle !== exp_first + exp.len()) begin errors++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cycle, exp_first + exp.len()); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", name, done_cnt); end
    endtask

    task automatic test_backpressure();
        string exp;
        exp = "-4444\015\012";
        do_start(32'hFFFFEEA4, 1'b1, 1'b0);
        collect(1'b0, 1, 5, 200);
        checks++; if (got_n !== exp.len()) begin errors++; $display("FAIL bp len: got %0d expected %0d", got_n, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL bp byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp hold: got %0d violations expected 0", hold_viol); end
        checks++; if (stall_seen !== 5) begin errors++; $display("FAIL bp stall_cycles: got %0d expected 5", stall_seen); end
        checks++; if (done_cycle !== 34 + 7 + 5) begin errors++; $display("FAIL bp done_cycle: got %0d expected %0d", done_cycle, 46); end
    endtask

    task automatic test_ignored_start();
        string exp;
        exp = "1234\015\012";
        do_start(32'd1234, 1'b0, 1'b0);
        inj_cycle = 5; inj_result = 32'd999;
        collect(1'b0, -1, 0, 200);
        inj_cycle = -1;
        checks++; if (got_n !== exp.len()) begin errors++; $display("FAIL ignore len: got %0d expected %0d", got_n, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL ignore byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        checks++; if (done_cycle !== 40) begin errors++; $display("FAIL ignore done_cycle: got %0d expected 40", done_cycle); end
    endtask

    task automatic test_reset_mid_digit();
        int  seen;
        int  resumed;
        bit  reached;
        seen = 0; reached = 1'b0; resumed = 0;
        do_start(32'd1234, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
            @(negedge clk);
            if (tx_valid) seen++;
            if (seen == 2) reached = 1'b1;
        end
        checks++; if (!reached) begin errors++; $display("FAIL rstmid reach: got no second byte expected one"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid valid: got %b expected 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b expected 0", busy); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid data: got %h expected 00", tx_data); end
        repeat (40) begin
            @(negedge clk);
            if (tx_valid || busy) resumed++;
        end
        checks++; if (resumed !== 0) begin errors++; $display("FAIL rstmid resume: got %0d active cycles expected 0", resumed); end
        test_value("after_rst", 1'b0, 32'd5, 1'b0, 1'b0, "5\015\012", 34);
    endtask

    initial begin
        test_reset();
        test_value("u1234", 1'b0, 32'd1234, 1'b0, 1'b0, "1234\015\012", 34);
        test_value("neg4444", 1'b0, 32'hFFFFEEA4, 1'b1, 1'b0, "-4444\015\012", 34);
        test_value("zero", 1'b0, 32'd0, 1'b1, 1'b0, "0\015\012", 34);
        test_value("int_min", 1'b0, 32'h80000000, 1'b1, 1'b0, "-2147483648\015\012", 34);
        test_value("u_80000000", 1'b0, 32'h80000000, 1'b0, 1'b0, "2147483648\015\012", 34);
        test_value("u_max", 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, "4294967295\015\012", 34);
        test_value("lf_max", 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, "4294967295\012", 34);
        test_value("err", 1'b0, 32'hFFFFEEA4, 1'b1, 1'b1, "ERR\015\012", 1);
        test_value("lf_err", 1'b1, 32'd42, 1'b0, 1'b1, "ERR\012", 1);
        test_backpressure();
        test_ignored_start();
        test_reset_mid_digit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
